// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter.
// Requester identity is a single bit; REQ0/REQ1 name the two values.
package sdram_arb_pkg;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: remembers which requester issued each outstanding read.
// Push and pop may coincide; the count only moves on a lone push or pop.
module arb_owner_fifo
  import sdram_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  req_id_t       push_id,
  input  logic          pop,
  output req_id_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  req_id_t         owner_q [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = owner_q[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++)
        owner_q[i] <= REQ0;
    end else begin
      if (do_push) begin
        owner_q[wr_ptr] <= push_id;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM port between two masters.
// Read returns are steered back to their issuer via the owner FIFO.
module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic              req0_read,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_writedata,
  output logic              req0_waitrequest,
  output logic [DATA_W-1:0] req0_readdata,
  output logic              req0_readdatavalid,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic              req1_read,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_writedata,
  output logic              req1_waitrequest,
  output logic [DATA_W-1:0] req1_readdata,
  output logic              req1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  output logic              err_orphan
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  req_id_t       head;
  req_id_t       rr_ptr;
  req_id_t       lock_id;
  req_id_t       gnt;
  logic          lock_v;
  logic          lock_hit;
  logic          gnt_v;
  logic          e0;
  logic          e1;
  logic          s_read;
  logic          s_write;
  logic          accept;
  logic          push;
  logic          pop;

  assign e0 = req0_read ? ~fifo_full : req0_write;
  assign e1 = req1_read ? ~fifo_full : req1_write;

  // a stalled request keeps its grant until accepted
  assign lock_hit = lock_v & (lock_id ? e1 : e0);

  always_comb begin
    gnt_v = rst_n & (e0 | e1);
    gnt   = rr_ptr;
    unique case (1'b1)
      lock_hit:              gnt = lock_id;
      (~lock_hit & e0 & ~e1): gnt = REQ0;
      (~lock_hit & ~e0 & e1): gnt = REQ1;
      default:               gnt = rr_ptr;
    endcase
  end

  assign s_read  = gnt ? req1_read  : req0_read;
  assign s_write = gnt ? req1_write : req0_write;

  assign mem_address   = gnt ? req1_address   : req0_address;
  assign mem_writedata = gnt ? req1_writedata : req0_writedata;
  assign mem_read      = gnt_v & s_read;
  assign mem_write     = gnt_v & s_write & ~s_read;

  assign req0_waitrequest = ~(gnt_v & (gnt == REQ0)) | mem_waitrequest;
  assign req1_waitrequest = ~(gnt_v & (gnt == REQ1)) | mem_waitrequest;

  assign accept = gnt_v & ~mem_waitrequest;
  assign push   = accept & s_read;
  assign pop    = mem_readdatavalid & ~fifo_empty;

  assign req0_readdata      = mem_readdata;
  assign req1_readdata      = mem_readdata;
  assign req0_readdatavalid = pop & (head == REQ0);
  assign req1_readdatavalid = pop & (head == REQ1);

  arb_owner_fifo #(.DEPTH(MAX_OUT)) u_owner_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (gnt),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= REQ0;
      lock_v     <= 1'b0;
      lock_id    <= REQ0;
      err_orphan <= 1'b0;
    end else begin
      if (accept)
        rr_ptr <= ~gnt;
      lock_v  <= gnt_v & mem_waitrequest;
      lock_id <= gnt;
      if (mem_readdatavalid & fifo_empty)
        err_orphan <= 1'b1;
    end
  end

  a_count_range: assert property (
    @(posedge clk) disable iff (!rst_n) fifo_count <= CW'(MAX_OUT));

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Bench for sdram_rr_arbiter: directed scenarios plus random traffic
// against a queue-based reference model and an SDRAM latency model.
module tb_sdram_rr_arbiter;

  localparam int MO = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] req0_address, req1_address;
  logic        req0_read, req0_write, req1_read, req1_write;
  logic [31:0] req0_writedata, req1_writedata;
  logic        req0_waitrequest, req1_waitrequest;
  logic [31:0] req0_readdata, req1_readdata;
  logic        req0_readdatavalid, req1_readdatavalid;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest, mem_readdatavalid;
  logic        err_orphan;

  sdram_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_address(req0_address), .req0_read(req0_read),
    .req0_write(req0_write), .req0_writedata(req0_writedata),
    .req0_waitrequest(req0_waitrequest), .req0_readdata(req0_readdata),
    .req0_readdatavalid(req0_readdatavalid),
    .req1_address(req1_address), .req1_read(req1_read),
    .req1_write(req1_write), .req1_writedata(req1_writedata),
    .req1_waitrequest(req1_waitrequest), .req1_readdata(req1_readdata),
    .req1_readdatavalid(req1_readdatavalid),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          t;
    logic [31:0] d;
  } ret_t;

  bit          m_rr, m_lkv, m_lkid, m_err;
  bit          owners[$];
  bit          rlog[$];
  ret_t        rq[$];
  logic [31:0] exp0[$], exp1[$];
  int          lat = 1;
  int          cyc = 0;
  bit          force_rdv = 0;
  bit          x0, x1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h20) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic model_reset();
    m_rr = 0; m_lkv = 0; m_lkid = 0; m_err = 0;
    owners.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic drive_idle();
    req0_read = 0; req0_write = 0; req1_read = 0; req1_write = 0;
    req0_address = 0; req1_address = 0;
    req0_writedata = 0; req1_writedata = 0;
    mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    rq.delete();
    force_rdv = 0;
  endtask

  // one bus cycle: entered and left at posedge+1
  task automatic step(input bit r0r, input bit r0w,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input bit r1r, input bit r1w,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input bit mw, output bit acc0, output bit acc1);
    bit f, e0, e1, gv, g, ready, rdv, pop, pid, rdg, wrg;
    logic [31:0] ag, dg;
    ret_t r;
    req0_read = r0r; req0_write = r0w;
    req0_address = a0; req0_writedata = d0;
    req1_read = r1r; req1_write = r1w;
    req1_address = a1; req1_writedata = d1;
    mem_waitrequest = mw;
    ready = rq.size() > 0 && rq[0].t <= cyc;
    rdv = ready || force_rdv;
    mem_readdatavalid = rdv;
    mem_readdata = ready ? rq[0].d : $urandom;
    f  = owners.size() >= MO;
    e0 = r0w | (r0r & !f);
    e1 = r1w | (r1r & !f);
    gv = 1;
    g  = 0;
    if (m_lkv && (m_lkid ? e1 : e0)) g = m_lkid;
    else if (e0 && e1) g = m_rr;
    else if (e0) g = 0;
    else if (e1) g = 1;
    else gv = 0;
    rdg = g ? r1r : r0r;
    wrg = g ? r1w : r0w;
    ag  = g ? a1 : a0;
    dg  = g ? d1 : d0;
    pop = rdv && owners.size() > 0;
    pid = pop ? owners[0] : 1'b0;
    #4;
    check_eq("mem_read", mem_read, gv & rdg);
    check_eq("mem_write", mem_write, gv & wrg & !rdg);
    if (gv) check_eq("mem_address", mem_address, ag);
    if (gv && wrg && !rdg) check_eq("mem_writedata", mem_writedata, dg);
    check_eq("req0_wait", req0_waitrequest, !(gv && g == 0) || mw);
    check_eq("req1_wait", req1_waitrequest, !(gv && g == 1) || mw);
    check_eq("req0_rdv", req0_readdatavalid, pop && !pid);
    check_eq("req1_rdv", req1_readdatavalid, pop && pid);
    check_eq("err_orphan", err_orphan, m_err);
    if (pop) begin
      if (pid) check_eq("rdata1", req1_readdata, exp1[0]);
      else     check_eq("rdata0", req0_readdata, exp0[0]);
      rlog.push_back(pid);
    end
    acc0 = gv && g == 0 && !mw;
    acc1 = gv && g == 1 && !mw;
    @(posedge clk);
    if (pop) begin
      void'(owners.pop_front());
      if (pid) void'(exp1.pop_front());
      else     void'(exp0.pop_front());
    end
    if (rdv && !pop) m_err = 1;
    if (ready) void'(rq.pop_front());
    if (gv && !mw) begin
      m_rr = !g;
      if (rdg) begin
        owners.push_back(g);
        r.t = cyc + lat;
        r.d = mem_data(ag);
        rq.push_back(r);
        if (g) exp1.push_back(r.d);
        else   exp0.push_back(r.d);
      end
    end
    m_lkv  = gv && mw;
    m_lkid = g;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, x0, x1);
  endtask

  bit          act [2];
  bit          crd [2];
  logic [31:0] ca [2];
  logic [31:0] cd [2];
  logic [31:0] a0, a1;
  logic [7:0]  seq;
  logic [2:0]  rl;
  int          n0, n1;

  initial begin
    drive_idle();
    rst_n = 1;
    #1;
    do_reset();

    // reset state, then single read from req0
    lat = 1;
    idle(1);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, x0, x1);
    check_eq("t1_acc", x0, 1);
    rlog.delete();
    idle(1);
    check_eq("t1_ret", rlog.size(), 1);

    // alternating writes
    do_reset();
    a0 = 32'h40; a1 = 32'h80; seq = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, a0, ~a0, 0, 1, a1, ~a1, 0, x0, x1);
      seq = {seq[6:0], x1};
      if (x0) begin a0 += 4; n0++; end
      if (x1) begin a1 += 4; n1++; end
    end
    check_eq("t2_n0", n0, 4);
    check_eq("t2_n1", n1, 4);
    check_eq("t2_seq", seq, 8'b0101_0101);

    // grant lock under waitrequest
    do_reset();
    step(0, 0, 0, 0, 0, 1, 32'h100, 1, 1, x0, x1);
    repeat (2) step(0, 1, 32'h200, 2, 0, 1, 32'h100, 1, 1, x0, x1);
    step(0, 1, 32'h200, 2, 0, 1, 32'h100, 1, 0, x0, x1);
    check_eq("t3_rel1", x1, 1);
    check_eq("t3_rel0", x0, 0);
    step(0, 1, 32'h200, 2, 0, 1, 32'h104, 3, 0, x0, x1);
    check_eq("t3_next0", x0, 1);

    // FIFO capacity with slow returns
    do_reset();
    lat = 10; n0 = 0;
    rlog.delete();
    for (int c = 0; c < 40; c++) begin
      step(n0 < 6, 0, 32'h1000 + 4 * n0, 0, 0, 0, 0, 0, 0, x0, x1);
      if (x0) n0++;
      if (c == 4)  check_eq("t4_cap", n0, 4);
      if (c == 10) check_eq("t4_samecyc", n0, 4);
      if (c == 11) check_eq("t4_unblock", n0, 5);
    end
    check_eq("t4_total", n0, 6);
    check_eq("t4_rets", rlog.size(), 6);

    // interleaved owners
    do_reset();
    lat = 1;
    rlog.delete();
    step(1, 0, 32'h300, 0, 0, 0, 0, 0, 0, x0, x1);
    check_eq("t5_a", x0, 1);
    step(0, 0, 0, 0, 1, 0, 32'h304, 0, 0, x0, x1);
    check_eq("t5_b", x1, 1);
    step(1, 0, 32'h308, 0, 0, 0, 0, 0, 0, x0, x1);
    check_eq("t5_c", x0, 1);
    idle(2);
    check_eq("t5_nret", rlog.size(), 3);
    if (rlog.size() == 3) begin
      rl = {rlog[0], rlog[1], rlog[2]};
      check_eq("t5_route", rl, 3'b010);
    end

    // orphan return
    force_rdv = 1;
    idle(1);
    force_rdv = 0;
    idle(1);
    check_eq("t6_orphan", err_orphan, 1);

    // async reset in the middle of a read burst
    do_reset();
    lat = 3; n0 = 0;
    for (int c = 0; c < 6; c++) begin
      step(1, 0, 32'h2000 + 4 * n0, 0, 0, 0, 0, 0, 0, x0, x1);
      if (x0) n0++;
    end
    req0_read = 1; req1_write = 1; mem_readdatavalid = 1;
    #2 rst_n = 0;
    #1;
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_wait0", req0_waitrequest, 1);
    check_eq("rst_wait1", req1_waitrequest, 1);
    check_eq("rst_rdv0", req0_readdatavalid, 0);
    check_eq("rst_rdv1", req1_readdatavalid, 0);
    check_eq("rst_err", err_orphan, 0);
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    idle(6);
    check_eq("rst_late_orphan", err_orphan, 1);

    // random traffic
    do_reset();
    act[0] = 0; act[1] = 0;
    for (int p = 0; p < 4; p++) begin
      lat = 1 + 2 * p;
      for (int c = 0; c < 400; c++) begin
        for (int n = 0; n < 2; n++)
          if (!act[n] && $urandom_range(0, 99) < 70) begin
            act[n] = 1;
            crd[n] = 1'($urandom_range(0, 1));
            ca[n]  = $urandom & 32'hFFFC;
            cd[n]  = $urandom;
          end
        step(act[0] & crd[0], act[0] & !crd[0], ca[0], cd[0],
             act[1] & crd[1], act[1] & !crd[1], ca[1], cd[1],
             $urandom_range(0, 99) < 15 * p, x0, x1);
        if (x0) act[0] = 0;
        if (x1) act[1] = 0;
      end
    end
    idle(20);
    check_eq("rand_drain", exp0.size() + exp1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
